param_nfa_engine: RTL

- Parametrised one-hot NFA payload matcher for a single linear pattern of up to NUM_STATES positions.
- Each position selects one of NUM_CLASSES pre-decoded character-class lines from the shared byte decoder, and may self-loop for "+" repetition.
- Adds optional start anchoring, a saturating byte-offset capture of the first match, a saturating match counter and an end-of-data result pulse.
- Sits in the payload engine array, fed by the class decoder. One instance per rule.

---
 rtl/param_nfa_engine.sv | 122 ++++++++++++
 1 files changed

// File: rtl/param_nfa_engine.sv
// One-hot NFA matcher for a single linear pattern with per-position "+" self-loops.
// Define PAYLOAD_NFA_MULTILINE_EN to let a newline class re-arm an anchored pattern.
module param_nfa_engine #(
  parameter int unsigned                  NUM_STATES  = 12,
  parameter int unsigned                  NUM_CLASSES = 32,
  parameter int unsigned                  SEL_W       = 5,
  parameter logic [NUM_STATES*SEL_W-1:0]  CLASS_SEL   = '0,
  parameter logic [NUM_STATES-1:0]        SELF_LOOP   = '0,
  parameter bit                           ANCHORED    = 1'b0,
  parameter int unsigned                  OFFSET_W    = 16,
  parameter int unsigned                  NL_CLASS    = 0
) (
  input  logic                   clk_i,
  input  logic                   sod_i,
  input  logic                   en_i,
  input  logic [NUM_CLASSES-1:0] in_cls_i,
  input  logic                   eod_i,
  output logic                   out_o,
  output logic                   result_valid_o,
  output logic [OFFSET_W-1:0]    first_offset_o,
  output logic [OFFSET_W-1:0]    match_count_o
);

  localparam logic [OFFSET_W-1:0] CntMax = '1;

  logic [NUM_STATES-1:0] cls_hit, pred, s_step, s_d, s_q;
  logic                  nl_hit, arm;
  logic                  first_byte_d, first_byte_q;
  logic                  out_d, out_q;
  logic                  rv_d, rv_q;
  logic                  pend_d, pend_q;
  logic [OFFSET_W-1:0]   byte_cnt_d, byte_cnt_q;
  logic [OFFSET_W-1:0]   fo_d, fo_q;
  logic [OFFSET_W-1:0]   mc_d, mc_q;

  // Selectors are elaboration-time constants; an out-of-range class reads as 0.
  for (genvar gi = 0; gi < NUM_STATES; gi++) begin : g_hit
    localparam int unsigned Sel = int'(CLASS_SEL[gi*SEL_W +: SEL_W]);
    if (Sel < NUM_CLASSES) begin : g_in
      assign cls_hit[gi] = in_cls_i[Sel];
    end else begin : g_out
      assign cls_hit[gi] = 1'b0;
    end
  end

`ifdef PAYLOAD_NFA_MULTILINE_EN
  if (ANCHORED && (NL_CLASS < NUM_CLASSES)) begin : g_nl
    assign nl_hit = in_cls_i[NL_CLASS];
  end else begin : g_no_nl
    assign nl_hit = 1'b0;
  end
`else
  assign nl_hit = 1'b0;
`endif

  always_comb begin
    arm = ANCHORED ? first_byte_q : 1'b1;
    pred = '0;
    pred[0] = arm;
    for (int i = 1; i < NUM_STATES; i++) begin
      pred[i] = s_q[i-1];
    end
    s_step = cls_hit & (pred | (SELF_LOOP & s_q));
  end

  always_comb begin
    s_d          = s_q;
    first_byte_d = first_byte_q;
    out_d        = out_q;
    pend_d       = pend_q;
    byte_cnt_d   = byte_cnt_q;
    fo_d         = fo_q;
    mc_d         = mc_q;
    rv_d         = en_i & (eod_i | pend_q);
    if (en_i) begin
      s_d          = s_step;
      first_byte_d = nl_hit;
      // A match completing on the eod byte earns a second result pulse next byte.
      pend_d       = eod_i & s_step[NUM_STATES-1];
      if (byte_cnt_q != CntMax) begin
        byte_cnt_d = byte_cnt_q + OFFSET_W'(1);
      end
      if (s_q[NUM_STATES-1]) begin
        out_d = 1'b1;
        if (mc_q != CntMax) begin
          mc_d = mc_q + OFFSET_W'(1);
        end
        if (!out_q) begin
          fo_d = byte_cnt_q - OFFSET_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (sod_i) begin
      s_q          <= '0;
      first_byte_q <= 1'b1;
      out_q        <= 1'b0;
      rv_q         <= 1'b0;
      pend_q       <= 1'b0;
      byte_cnt_q   <= '0;
      fo_q         <= '0;
      mc_q         <= '0;
    end else begin
      s_q          <= s_d;
      first_byte_q <= first_byte_d;
      out_q        <= out_d;
      rv_q         <= rv_d;
      pend_q       <= pend_d;
      byte_cnt_q   <= byte_cnt_d;
      fo_q         <= fo_d;
      mc_q         <= mc_d;
    end
  end

  assign out_o          = out_q;
  assign result_valid_o = rv_q;
  assign first_offset_o = fo_q;
  assign match_count_o  = mc_q;

endmodule
